// File: rtl/stopwatch_pkg.sv
// Shared digit types, time record and lap-word width for the lap-capturing BCD stopwatch.
// Defining STOPWATCH_HOURS_EN adds the hour pair to the time record and lap word.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX9 = 4'd9;
    localparam bcd_t BCD_MAX5 = 4'd5;

`ifdef STOPWATCH_HOURS_EN
    typedef struct packed {
        bcd_t hh;
        bcd_t hl;
        bcd_t mh;
        bcd_t ml;
        bcd_t sh;
        bcd_t sl;
        bcd_t msh;
        bcd_t msl;
    } time_t;
    localparam int LAP_W = 32;
`else
    typedef struct packed {
        bcd_t mh;
        bcd_t ml;
        bcd_t sh;
        bcd_t sl;
        bcd_t msh;
        bcd_t msl;
    } time_t;
    localparam int LAP_W = 24;
`endif

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; advances on en and rolls back to 0 after MAX.
// at_max is combinational so the next digit's enable forms in the same cycle.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX9
)
(
    input  logic CLK,
    input  logic CLR,
    input  logic en,
    output bcd_t q,
    output logic at_max
);

    assign at_max = (q == MAX);

    // NOTE: clocked state uses <= so every digit samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch (centiseconds..minutes) with a tick divider and a first-word-fall-through lap FIFO.
// Defining STOPWATCH_HOURS_EN adds HH/HL outputs, wraps at 99:59:59.99 and widens LAP_DATA to 32 bits.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV   = 500000,
    parameter int LAP_DEPTH = 4
)
(
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         PAUSE,
    input  logic                         LAP,
    input  logic                         RD,
`ifdef STOPWATCH_HOURS_EN
    output logic [3:0]                   HH,
    output logic [3:0]                   HL,
`endif
    output logic [3:0]                   MSH,
    output logic [3:0]                   MSL,
    output logic [3:0]                   SH,
    output logic [3:0]                   SL,
    output logic [3:0]                   MH,
    output logic [3:0]                   ML,
    output logic [LAP_W-1:0]             LAP_DATA,
    output logic                         LAP_VALID,
    output logic [$clog2(LAP_DEPTH):0]   LAP_CNT,
    output logic                         LAP_OVF,
    output logic                         WRAP
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int                PTR_W    = $clog2(LAP_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LAP_DEPTH);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // Divider freezes under PAUSE so a resume keeps the sub-tick phase.
    assign tick = !PAUSE && (div_cnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            div_cnt <= '0;
        end else if (!PAUSE) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    logic msl_max, msh_max, sl_max, sh_max, ml_max, mh_max;
    logic en_msh, en_sl, en_sh, en_ml, en_mh;
    logic roll;

    assign en_msh = tick   & msl_max;
    assign en_sl  = en_msh & msh_max;
    assign en_sh  = en_sl  & sl_max;
    assign en_ml  = en_sh  & sh_max;
    assign en_mh  = en_ml  & ml_max;

    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_msl (.CLK(CLK), .CLR(CLR), .en(tick),   .q(MSL), .at_max(msl_max));
    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_msh (.CLK(CLK), .CLR(CLR), .en(en_msh), .q(MSH), .at_max(msh_max));
    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_sl  (.CLK(CLK), .CLR(CLR), .en(en_sl),  .q(SL),  .at_max(sl_max));
    bcd_digit_cnt #(.MAX(BCD_MAX5)) u_sh  (.CLK(CLK), .CLR(CLR), .en(en_sh),  .q(SH),  .at_max(sh_max));
    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_ml  (.CLK(CLK), .CLR(CLR), .en(en_ml),  .q(ML),  .at_max(ml_max));
    bcd_digit_cnt #(.MAX(BCD_MAX5)) u_mh  (.CLK(CLK), .CLR(CLR), .en(en_mh),  .q(MH),  .at_max(mh_max));

    time_t cur_time;

`ifdef STOPWATCH_HOURS_EN
    logic hl_max, hh_max;
    logic en_hl, en_hh;

    assign en_hl = en_mh & mh_max;
    assign en_hh = en_hl & hl_max;
    assign roll  = en_hh & hh_max;

    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_hl (.CLK(CLK), .CLR(CLR), .en(en_hl), .q(HL), .at_max(hl_max));
    bcd_digit_cnt #(.MAX(BCD_MAX9)) u_hh (.CLK(CLK), .CLR(CLR), .en(en_hh), .q(HH), .at_max(hh_max));

    assign cur_time = {HH, HL, MH, ML, SH, SL, MSH, MSL};
`else
    assign roll     = en_mh & mh_max;
    assign cur_time = {MH, ML, SH, SL, MSH, MSL};
`endif

    // WRAP is high during the first cycle that shows the all-zero time.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= roll;
        end
    end

    logic [LAP_W-1:0] lap_mem [LAP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             rd_fire;
    logic             wr_fire;

    assign LAP_VALID = (LAP_CNT != '0);
    assign full      = (LAP_CNT == CNT_FULL);
    assign rd_fire   = RD && LAP_VALID;
    assign wr_fire   = LAP && (!full || rd_fire);
    assign LAP_DATA  = LAP_VALID ? lap_mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            LAP_CNT <= '0;
            LAP_OVF <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   LAP_CNT <= LAP_CNT + 1'b1;
                2'b01:   LAP_CNT <= LAP_CNT - 1'b1;
                default: ;
            endcase
            if (LAP && !wr_fire) LAP_OVF <= 1'b1;
        end
    end

    // NOTE: the lap storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge CLK) begin
        if (wr_fire) lap_mem[wr_ptr] <= cur_time;
    end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: directed sequences, a FIFO vector table and random stimulus
// checked against a centisecond-count reference model.
module tb_stopwatch_lap;
    import stopwatch_pkg::*;

    localparam int CLK_DIV   = 2;
    localparam int LAP_DEPTH = 4;
    localparam int CNT_W     = $clog2(LAP_DEPTH) + 1;
`ifdef STOPWATCH_HOURS_EN
    localparam int MAX_CS = 36000000;
`else
    localparam int MAX_CS = 360000;
`endif

    logic             CLK = 1'b0;
    logic             CLR = 1'b1;
    logic             PAUSE = 1'b0;
    logic             LAP = 1'b0;
    logic             RD = 1'b0;
    logic [3:0]       MSH, MSL, SH, SL, MH, ML;
`ifdef STOPWATCH_HOURS_EN
    logic [3:0]       HH, HL;
`endif
    logic [LAP_W-1:0] LAP_DATA;
    logic             LAP_VALID;
    logic [CNT_W-1:0] LAP_CNT;
    logic             LAP_OVF;
    logic             WRAP;

    always #5 CLK = ~CLK;

    stopwatch_lap #(.CLK_DIV(CLK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
        .CLK(CLK), .CLR(CLR), .PAUSE(PAUSE), .LAP(LAP), .RD(RD),
`ifdef STOPWATCH_HOURS_EN
        .HH(HH), .HL(HL),
`endif
        .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL), .MH(MH), .ML(ML),
        .LAP_DATA(LAP_DATA), .LAP_VALID(LAP_VALID), .LAP_CNT(LAP_CNT),
        .LAP_OVF(LAP_OVF), .WRAP(WRAP)
    );

    logic [LAP_W-1:0] dut_t;
`ifdef STOPWATCH_HOURS_EN
    assign dut_t = {HH, HL, MH, ML, SH, SL, MSH, MSL};
`else
    assign dut_t = {MH, ML, SH, SL, MSH, MSL};
`endif

    function automatic logic [LAP_W-1:0] to_bcd(input int cs);
        logic [31:0] w;
        w = '0;
        w[3:0]   = 4'(cs % 10);
        w[7:4]   = 4'((cs / 10) % 10);
        w[11:8]  = 4'((cs / 100) % 10);
        w[15:12] = 4'((cs / 1000) % 6);
        w[19:16] = 4'((cs / 6000) % 10);
        w[23:20] = 4'((cs / 60000) % 6);
        w[27:24] = 4'((cs / 360000) % 10);
        w[31:28] = 4'((cs / 3600000) % 10);
        return LAP_W'(w);
    endfunction

    // Reference model: elapsed time as a plain centisecond count, laps in a queue.
    int               m_cs = 0;
    int               m_div = 0;
    logic [LAP_W-1:0] m_q[$];
    bit               m_ovf = 1'b0;
    bit               m_wrap = 1'b0;
    int               pre_cs = 0;
    int               pre_seq = 0;
    int               m_seq = 0;

    always @(posedge CLK) begin
        bit tick, pop, full;
        if (m_seq != pre_seq) begin
            m_cs  = pre_cs;
            m_seq = pre_seq;
        end
        if (CLR) begin
            m_cs = 0;
            m_div = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_wrap = 1'b0;
        end else begin
            tick = !PAUSE && (m_div == CLK_DIV - 1);
            pop  = RD && (m_q.size() != 0);
            full = (m_q.size() == LAP_DEPTH);
            if (pop) void'(m_q.pop_front());
            if (LAP) begin
                if (!full || pop) m_q.push_back(to_bcd(m_cs));
                else m_ovf = 1'b1;
            end
            m_wrap = tick && (m_cs == MAX_CS - 1);
            if (!PAUSE) m_div = (m_div + 1) % CLK_DIV;
            if (tick) m_cs = (m_cs + 1) % MAX_CS;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " time"},  32'(dut_t),     32'(to_bcd(m_cs)));
        check({tag, " valid"}, 32'(LAP_VALID), 32'(m_q.size() != 0));
        check({tag, " cnt"},   32'(LAP_CNT),   32'(m_q.size()));
        check({tag, " ovf"},   32'(LAP_OVF),   32'(m_ovf));
        check({tag, " wrap"},  32'(WRAP),      32'(m_wrap));
        check({tag, " data"},  32'(LAP_DATA),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (dut_t !== to_bcd(target) && n < budget) begin
            step();
            n++;
        end
        check({tag, " reach"}, 32'(dut_t), 32'(to_bcd(target)));
    endtask

    task automatic wait_change(input logic [LAP_W-1:0] from);
        int n = 0;
        while (dut_t === from && n < 4 * CLK_DIV) begin
            step();
            n++;
        end
    endtask

    logic [LAP_W-1:0] pre_w;

    // Loads the digit registers directly so rollover points are reachable quickly.
    task preload(input int cs);
        pre_w = to_bcd(cs);
        force dut.u_msl.q = pre_w[3:0];
        force dut.u_msh.q = pre_w[7:4];
        force dut.u_sl.q  = pre_w[11:8];
        force dut.u_sh.q  = pre_w[15:12];
        force dut.u_ml.q  = pre_w[19:16];
        force dut.u_mh.q  = pre_w[23:20];
`ifdef STOPWATCH_HOURS_EN
        force dut.u_hl.q  = pre_w[27:24];
        force dut.u_hh.q  = pre_w[31:28];
`endif
        #1;
        release dut.u_msl.q;
        release dut.u_msh.q;
        release dut.u_sl.q;
        release dut.u_sh.q;
        release dut.u_ml.q;
        release dut.u_mh.q;
`ifdef STOPWATCH_HOURS_EN
        release dut.u_hl.q;
        release dut.u_hh.q;
`endif
        pre_cs = cs;
        pre_seq++;
    endtask

    typedef struct {
        bit lap;
        bit rd;
        int cnt;
        bit valid;
        bit ovf;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit wrap_seen;

        tbl[0]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 4, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 3, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1, 1'b1, 1'b1};

        // Reset overrides LAP, RD and a running count.
        @(negedge CLK);
        CLR = 1'b1; LAP = 1'b1; RD = 1'b1;
        repeat (3) step();
        check("reset time",  32'(dut_t),     32'd0);
        check("reset valid", 32'(LAP_VALID), 32'd0);
        check("reset cnt",   32'(LAP_CNT),   32'd0);
        check("reset ovf",   32'(LAP_OVF),   32'd0);
        check("reset wrap",  32'(WRAP),      32'd0);
        check("reset data",  32'(LAP_DATA),  32'd0);
        CLR = 1'b0; LAP = 1'b0; RD = 1'b0;

        // 200 cycles at two cycles per tick is exactly one second.
        wrap_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (WRAP) wrap_seen = 1'b1;
            compare_all("run200");
        end
        check("run200 one second", 32'(dut_t), 32'h000100);
        check("run200 no wrap", 32'(wrap_seen), 32'd0);

        // Pause with the divider one cycle short of a tick; resume must tick immediately.
        clear();
        run_until(5, 40, "pause");
        step();
        PAUSE = 1'b1;
        for (int i = 0; i < 50; i++) step();
        check("pause hold", 32'(dut_t), 32'h000005);
        compare_all("pause");
        PAUSE = 1'b0;
        step();
        check("pause resume phase", 32'(dut_t), 32'h000006);
        compare_all("resume");

        // Two laps then a pop.
        clear();
        run_until(7, 40, "lap7");
        LAP = 1'b1; step(); LAP = 1'b0;
        run_until(12, 40, "lap12");
        LAP = 1'b1; step(); LAP = 1'b0;
        check("lap two cnt",  32'(LAP_CNT),  32'd2);
        check("lap two head", 32'(LAP_DATA), 32'h000007);
        RD = 1'b1; step(); RD = 1'b0;
        check("lap pop head", 32'(LAP_DATA), 32'h000012);
        check("lap pop cnt",  32'(LAP_CNT),  32'd1);
        compare_all("lap");

        // FIFO occupancy, overflow and simultaneous LAP/RD vectors.
        clear();
        for (int i = 0; i < 13; i++) begin
            LAP = tbl[i].lap;
            RD  = tbl[i].rd;
            step();
            LAP = 1'b0;
            RD  = 1'b0;
            check($sformatf("vec%0d cnt", i),   32'(LAP_CNT),   32'(tbl[i].cnt));
            check($sformatf("vec%0d valid", i), 32'(LAP_VALID), 32'(tbl[i].valid));
            check($sformatf("vec%0d ovf", i),   32'(LAP_OVF),   32'(tbl[i].ovf));
            compare_all($sformatf("vec%0d", i));
        end

        // Reset mid-run with three entries held and overflow set.
        LAP = 1'b1; step(); step(); LAP = 1'b0;
        check("pre-clr cnt", 32'(LAP_CNT), 32'd3);
        clear();
        check("clr time",  32'(dut_t),     32'd0);
        check("clr valid", 32'(LAP_VALID), 32'd0);
        check("clr ovf",   32'(LAP_OVF),   32'd0);
        check("clr cnt",   32'(LAP_CNT),   32'd0);

        // Minute carry and full rollover, each in a single tick.
        preload(5999);
        check("preload 59.99", 32'(dut_t), 32'h005999);
        wait_change(to_bcd(5999));
        check("minute carry", 32'(dut_t), 32'h010000);
        compare_all("carry");
        preload(MAX_CS - 1);
        wait_change(to_bcd(MAX_CS - 1));
        check("wrap digits", 32'(dut_t), 32'd0);
        check("wrap pulse",  32'(WRAP),  32'd1);
        compare_all("wrap");
        step();
        check("wrap one cycle", 32'(WRAP), 32'd0);
        compare_all("post wrap");

        // Random traffic against the model.
        clear();
        for (int i = 0; i < 3000; i++) begin
            PAUSE = ($urandom_range(0, 9) == 0);
            LAP   = ($urandom_range(0, 4) == 0);
            RD    = ($urandom_range(0, 3) == 0);
            CLR   = ($urandom_range(0, 199) == 0);
            step();
            compare_all("rand");
        end
        CLR = 1'b0; PAUSE = 1'b0; LAP = 1'b0; RD = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
